// File: rtl/instr_fetch_unit_if.sv
// Purpose: bundles the fetch-unit ports: the control-unit handshake, the
//          instruction-memory request/ack channel and the PC/IR status outputs.
// Modports: master = fetch unit side (drives mem_req/mem_addr, pc, ir, status),
//           slave  = environment side (control unit + instruction memory).
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              fetch_start;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic [DATA_W-1:0] ir;
  logic              fetch_done;
  logic              busy;
  logic              addr_err;

  modport master (
    input  fetch_start, redirect_valid, redirect_pc, mem_ack, mem_rdata,
    output mem_req, mem_addr, pc, pc_plus1, ir, fetch_done, busy, addr_err
  );

  modport slave (
    output fetch_start, redirect_valid, redirect_pc, mem_ack, mem_rdata,
    input  mem_req, mem_addr, pc, pc_plus1, ir, fetch_done, busy, addr_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose: owns the PC, issues one word read per fetch_start, latches the word into IR.
// Latency: fetch_start in cycle 0, zero-wait ack in cycle 2 -> fetch_done pulse in cycle 3.
// Backpressure: mem_req held until mem_ack; fetch_start ignored unless IDLE (no queuing).
// Ports: clk/reset (sync, active-high) plus bus (master modport): fetch_start,
//   redirect_valid/redirect_pc in; mem_req/mem_addr out, mem_ack/mem_rdata in;
//   pc, pc_plus1, ir, fetch_done, busy, addr_err out.
module instr_fetch_unit #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              squash_q, squash_d;
  logic              err_q, err_d;
  logic              mem_req;
  logic              fetch_done;
  logic              pc_legal;

  assign pc_legal = (pc_q < DEPTH_A);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      squash_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      squash_q <= squash_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    squash_d   = squash_q;
    err_d      = err_q;
    mem_req    = 1'b0;
    fetch_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A redirect landing with fetch_start still lets the fetch go ahead;
        // the request in REQ then uses the redirected pc.
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
        if (bus.fetch_start)    state_d = S_REQ;
      end

      S_REQ: begin
        if (!pc_legal) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          if (bus.redirect_valid) pc_d = bus.redirect_pc;
        end else begin
          mem_req = 1'b1;
          state_d = S_WAIT;
          // The request for the old pc is already out; mark it stale.
          if (bus.redirect_valid) begin
            pc_d     = bus.redirect_pc;
            squash_d = 1'b1;
          end
        end
      end

      S_WAIT: begin
        mem_req = 1'b1;
        if (bus.redirect_valid) begin
          // Redirect wins over any data in flight, even a coincident ack.
          pc_d = bus.redirect_pc;
          if (bus.mem_ack) begin
            squash_d = 1'b0;
            state_d  = S_REQ;
          end else begin
            squash_d = 1'b1;
          end
        end else if (bus.mem_ack) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = S_REQ;
          end else begin
            ir_d    = bus.mem_rdata;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // pc still names the word in ir during DONE; it advances on the way out.
        fetch_done = 1'b1;
        state_d    = S_IDLE;
        pc_d       = bus.redirect_valid ? bus.redirect_pc : pc_q + ADDR_W'(1);
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = pc_q;
  assign bus.pc         = pc_q;
  assign bus.pc_plus1   = pc_q + ADDR_W'(1);
  assign bus.ir         = ir_q;
  assign bus.fetch_done = fetch_done;
  assign bus.busy       = (state_q == S_REQ) || (state_q == S_WAIT);
  assign bus.addr_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose: directed and randomized checks of instr_fetch_unit against a
//          transaction-level model (expected request addresses, latency, ir, pc).
// Ports: instantiates instr_fetch_unit_if and drives its slave-side signals.
module tb_instr_fetch_unit;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int done_count = 0;
  int exp_done   = 0;

  logic [31:0] mem [DEPTH];
  logic [31:0] exp_pc;
  logic [31:0] exp_ir;
  logic        exp_err;

  always @(negedge clk) if (bus.fetch_done === 1'b1) done_count++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'(DEPTH)) return mem[a[7:0]];
    return 32'hBAD0BAD0;
  endfunction

  task automatic do_redirect(input logic [31:0] rpc);
    logic [31:0] nxt;
    nxt = rpc + 32'd1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = rpc;
    step();
    bus.redirect_valid = 1'b0;
    check("redir_pc", bus.pc, rpc);
    check("redir_pc_plus1", bus.pc_plus1, nxt);
    exp_pc = rpc;
  endtask

  // One legal fetch. d = extra wait cycles before ack; optional redirect
  // arriving in the (rk+1)-th WAIT cycle of the first request.
  task automatic run_fetch(input int d, input bit redir, input int rk,
                           input logic [31:0] rpc, input logic [31:0] stale,
                           input bit noise);
    int cyc, w, nreq, exp_lat;
    bit prev_req, prev_ack, prev_squash, seen_done, is_new, ack_now;
    logic [31:0] first_addr, second_addr, start_pc, final_pc, nxt;
    start_pc = exp_pc;
    final_pc = redir ? rpc : exp_pc;
    exp_lat  = 3 + d + (redir ? 2 + d : 0);
    cyc = 0; w = 0; nreq = 0;
    prev_req = 0; prev_ack = 0; prev_squash = 0; seen_done = 0;
    first_addr = 'x; second_addr = 'x;
    bus.fetch_start = 1'b1;
    step();
    cyc = 1;
    while (cyc <= exp_lat + 6) begin
      bus.fetch_start    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.mem_ack        = 1'b0;
      bus.mem_rdata      = $urandom;
      if (bus.fetch_done === 1'b1) begin
        seen_done = 1;
        break;
      end
      if (prev_squash) check("ir_kept_on_squash", bus.ir, exp_ir);
      prev_squash = 0;
      ack_now = 0;
      if (bus.mem_req === 1'b1) begin
        is_new = !prev_req || prev_ack;
        if (is_new) begin
          w = 0;
          nreq++;
          if (nreq == 1) first_addr = bus.mem_addr;
          else if (nreq == 2) second_addr = bus.mem_addr;
        end else begin
          w++;
          if (!(redir && nreq == 1 && w > rk + 1))
            check("addr_held", bus.mem_addr, (nreq == 1) ? first_addr : second_addr);
        end
        if (w == d + 1) begin
          ack_now       = 1;
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = (redir && nreq == 1) ? stale
                                               : mem_word((nreq == 1) ? first_addr : second_addr);
          prev_squash   = redir && nreq == 1;
        end
        if (redir && nreq == 1 && w == rk + 1) begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = rpc;
        end
        if (noise) bus.fetch_start = 1'($urandom_range(0, 1));
      end
      prev_req = (bus.mem_req === 1'b1);
      prev_ack = ack_now;
      step();
      cyc++;
    end
    check("done_seen", seen_done, 1);
    check("latency", cyc, exp_lat);
    check("req_count", nreq, redir ? 2 : 1);
    check("req0_addr", first_addr, start_pc);
    if (redir) check("req1_addr", second_addr, rpc);
    exp_ir = mem_word(final_pc);
    check("ir", bus.ir, exp_ir);
    check("pc_in_done", bus.pc, final_pc);
    check("busy_in_done", bus.busy, 0);
    check("addr_err", bus.addr_err, exp_err);
    // Stray fetch_start / ack while DONE and IDLE must be ignored.
    bus.fetch_start = noise;
    bus.mem_ack     = noise;
    bus.mem_rdata   = 32'hA5A5A5A5;
    step();
    bus.fetch_start = 1'b0;
    exp_pc = final_pc + 32'd1;
    nxt    = exp_pc + 32'd1;
    check("done_pulse_len", bus.fetch_done, 0);
    check("pc_next", bus.pc, exp_pc);
    check("pc_plus1", bus.pc_plus1, nxt);
    check("ir_hold", bus.ir, exp_ir);
    step();
    bus.mem_ack = 1'b0;
    check("no_queued_fetch", bus.mem_req, 0);
    check("ir_idle", bus.ir, exp_ir);
    exp_done++;
  endtask

  task automatic run_illegal();
    logic [31:0] p;
    p = exp_pc;
    bus.fetch_start = 1'b1;
    step();
    bus.fetch_start = 1'b0;
    check("ill_busy_req", bus.busy, 1);
    check("ill_no_req0", bus.mem_req, 0);
    step();
    check("ill_err", bus.addr_err, 1);
    check("ill_idle", bus.busy, 0);
    check("ill_no_req1", bus.mem_req, 0);
    check("ill_no_done", bus.fetch_done, 0);
    check("ill_pc", bus.pc, p);
    exp_err = 1'b1;
  endtask

  initial begin
    int d, rk;
    bit rd;
    logic [31:0] rpc;

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h8C220004;
    bus.fetch_start = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    reset = 1'b1;
    step(); step();
    check("rst_pc", bus.pc, 0);
    check("rst_ir", bus.ir, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_done", bus.fetch_done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.addr_err, 0);
    reset = 1'b0;
    exp_pc = 0; exp_ir = 0; exp_err = 0;

    // Single zero-wait fetch from address 0.
    run_fetch(0, 0, 0, 0, 0, 0);

    // Four back-to-back fetches with 3 extra wait cycles each.
    exp_pc = 0;
    do_redirect(32'h0);
    for (int i = 0; i < 4; i++) run_fetch(3, 0, 0, 0, 0, 1);
    check("four_dones", done_count, exp_done);

    // Redirect mid-WAIT to 0x40, stale ack data discarded.
    run_fetch(2, 1, 1, 32'h40, 32'hDEADBEEF, 0);
    // Redirect coincident with ack.
    run_fetch(1, 1, 1, 32'h22, 32'hDEADBEEF, 0);

    // fetch_start and redirect in the same IDLE cycle.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h10;
    exp_pc = 32'h10;
    run_fetch(0, 0, 0, 0, 0, 0);

    // Last legal word, then an illegal fetch at 0x100, then recovery.
    do_redirect(32'hFF);
    run_fetch(1, 0, 0, 0, 0, 0);
    run_illegal();
    do_redirect(32'h5);
    run_fetch(0, 0, 0, 0, 0, 0);
    do_redirect(32'hFFFFFFFF);
    run_illegal();

    // Reset while in WAIT; the late ack must be ignored.
    do_redirect(32'h7);
    bus.fetch_start = 1'b1;
    step();
    bus.fetch_start = 1'b0;
    step();
    check("rst_mid_req", bus.mem_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_req_drop", bus.mem_req, 0);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h12345678;
    step();
    bus.mem_ack = 1'b0;
    check("rst_mid_pc", bus.pc, 0);
    check("rst_mid_ir", bus.ir, 0);
    check("rst_mid_done", bus.fetch_done, 0);
    check("rst_mid_err", bus.addr_err, 0);
    step();
    check("rst_mid_idle", bus.busy, 0);
    exp_pc = 0; exp_ir = 0; exp_err = 0;

    // Randomized fetches.
    for (int i = 0; i < 40; i++) begin
      if (exp_pc >= 32'(DEPTH)) begin
        run_illegal();
        do_redirect(32'($urandom_range(0, DEPTH - 1)));
      end else if ($urandom_range(0, 3) == 0) begin
        do_redirect(32'($urandom_range(DEPTH - 8, DEPTH - 1)));
      end
      d   = $urandom_range(0, 4);
      rd  = ($urandom_range(0, 2) == 0);
      rk  = $urandom_range(0, d);
      rpc = 32'($urandom_range(0, DEPTH - 1));
      run_fetch(d, rd, rk, rpc, $urandom, 1'($urandom_range(0, 1)));
    end
    step();
    check("done_total", done_count, exp_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
